// File: rtl/irq_hub.sv
// irq_hub: timer/external interrupt hub with lowest-index grant and CPU ack.
// Define IRQ_HUB_OVERRUN_EN to add per-channel overrun flags at addr NUM_CH+2.
module irq_hub #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  parameter logic [7:0] TIMER_MASK = 8'h01,
  parameter int RESET_LIMIT = 100
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] ext_src,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              irq,
  output logic [2:0]        irq_id,
  input  logic              irq_ack
);
  localparam logic [NUM_CH-1:0] TMASK = TIMER_MASK[NUM_CH-1:0];
  localparam logic [3:0] A_PEND = 4'(NUM_CH + 1);
  logic [NUM_CH-1:0] en_q, en_d, pend_q, pend_d, s1_q, s2_q, prev_q, evt, gnt;
  logic [CNT_W-1:0] lim_q [NUM_CH];
  logic [CNT_W-1:0] lim_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic unused;
  assign unused = ^cfg_wdata;
`ifdef IRQ_HUB_OVERRUN_EN
  localparam logic [3:0] A_OVR = 4'(NUM_CH + 2);
  logic [NUM_CH-1:0] ovr_q, ovr_d;
`endif
  always_comb begin
    en_d = en_q;
    lim_d = lim_q;
    cnt_d = cnt_q;
    evt = '0;
    gnt = '0;
    irq_id = '0;
    cfg_rdata = '0;
    // descending scan so the lowest pending+enabled channel is left as the grant
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pend_q[i] && en_q[i]) begin
        gnt = '0;
        gnt[i] = 1'b1;
        irq_id = 3'(i);
      end
    irq = |gnt;
    for (int i = 0; i < NUM_CH; i++) begin
      evt[i] = TMASK[i] ? (en_q[i] && lim_q[i] != '0 && cnt_q[i] == lim_q[i] - 1'b1)
                        : (s2_q[i] && !prev_q[i]);
      cnt_d[i] = (!TMASK[i] || !en_q[i] || lim_q[i] == '0 || evt[i]) ? '0 : cnt_q[i] + 1'b1;
      if (cfg_we && cfg_addr == 4'(i + 1)) begin
        lim_d[i] = cfg_wdata[CNT_W-1:0];
        cnt_d[i] = '0;
      end
      if (cfg_addr == 4'(i + 1)) cfg_rdata = 32'(lim_q[i]);
    end
    if (cfg_we && cfg_addr == 4'd0) en_d = cfg_wdata[NUM_CH-1:0];
    // a new event on the acked channel wins over the clear
    pend_d = (pend_q & ~(irq_ack ? gnt : '0)) | evt;
    if (cfg_addr == 4'd0) cfg_rdata = 32'(en_q);
    if (cfg_addr == A_PEND) cfg_rdata = 32'(pend_q);
`ifdef IRQ_HUB_OVERRUN_EN
    ovr_d = (cfg_we && cfg_addr == A_OVR) ? ovr_q & ~cfg_wdata[NUM_CH-1:0] : ovr_q;
    ovr_d = ovr_d | (evt & pend_q);
    if (cfg_addr == A_OVR) cfg_rdata = 32'(ovr_q);
`endif
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q <= '1;
      pend_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      lim_q <= '{default: CNT_W'(RESET_LIMIT)};
      cnt_q <= '{default: '0};
`ifdef IRQ_HUB_OVERRUN_EN
      ovr_q <= '0;
`endif
    end else begin
      en_q <= en_d;
      pend_q <= pend_d;
      s1_q <= ext_src;
      s2_q <= s1_q;
      prev_q <= s2_q;
      lim_q <= lim_d;
      cnt_q <= cnt_d;
`ifdef IRQ_HUB_OVERRUN_EN
      ovr_q <= ovr_d;
`endif
    end
  end
endmodule

// File: tb/tb_irq_hub.sv
// tb_irq_hub: directed scenarios plus randomized traffic checked against an
// event-level reference model of the interrupt hub.
module tb_irq_hub;
  localparam int N = 4;
  localparam logic [7:0] TM = 8'h01;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic cfg_we = 1'b0;
  logic irq_ack = 1'b0;
  logic [N-1:0] ext_src = '0;
  logic [3:0] cfg_addr = 4'(N + 1);
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic irq;
  logic [2:0] irq_id;
  int n_chk = 0;
  int n_pass = 0;
  logic [N-1:0] m_en, m_pend, m_ovr;
  int m_lim[N];
  int m_ticks[N];
  logic [N-1:0] samp[$];

  irq_hub #(.NUM_CH(N), .CNT_W(16), .TIMER_MASK(TM), .RESET_LIMIT(100)) dut (
    .clk(clk), .rstn(rstn), .ext_src(ext_src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_act();
    return m_pend & m_en;
  endfunction

  function automatic int m_id();
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_rd(input int a);
    if (a == 0) return 32'(m_en);
    if (a >= 1 && a <= N) return 32'(m_lim[a-1]);
    if (a == N + 1) return 32'(m_pend);
    if (a == N + 2) return 32'(m_ovr);
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_en = '1;
    m_pend = '0;
    m_ovr = '0;
    for (int i = 0; i < N; i++) begin
      m_lim[i] = 100;
      m_ticks[i] = 0;
    end
    samp.delete();
  endtask

  // Advance one clock edge: update the model from the pre-edge inputs, then
  // step the DUT and return 1 time unit after the edge.
  task automatic tick();
    logic [N-1:0] evt, hit;
    int n, a;
    evt = '0;
    hit = '0;
    n = samp.size();
    a = int'(cfg_addr);
    for (int i = 0; i < N; i++) begin
      if (TM[i]) begin
        if (m_en[i] && m_lim[i] != 0) begin
          m_ticks[i]++;
          evt[i] = (m_ticks[i] % m_lim[i]) == 0;
        end else m_ticks[i] = 0;
      end else
        evt[i] = (n >= 2 && samp[n-2][i]) && !(n >= 3 && samp[n-3][i]);
    end
    if (irq_ack && m_act() != '0) hit[m_id()] = 1'b1;
`ifdef IRQ_HUB_OVERRUN_EN
    if (cfg_we && a == N + 2) m_ovr = m_ovr & ~cfg_wdata[N-1:0];
    m_ovr = m_ovr | (evt & m_pend);
`endif
    m_pend = (m_pend & ~hit) | evt;
    if (cfg_we && a == 0) m_en = cfg_wdata[N-1:0];
    if (cfg_we && a >= 1 && a <= N) begin
      m_lim[a-1] = int'(cfg_wdata[15:0]);
      m_ticks[a-1] = 0;
    end
    samp.push_back(ext_src);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    cfg_addr = 4'(N + 1);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    n_chk++; if (irq !== 1'b0 || irq_id !== 3'd0) $display("FAIL reset_out irq=%0b id=%0d want 0/0", irq, irq_id); else n_pass++;
    cfg_addr = 4'd0; #1;
    n_chk++; if (cfg_rdata !== 32'hf) $display("FAIL reset_enable got %h want 0000000f", cfg_rdata); else n_pass++;
    cfg_addr = 4'd1; #1;
    n_chk++; if (cfg_rdata !== 32'd100) $display("FAIL reset_limit0 got %0d want 100", cfg_rdata); else n_pass++;
    cfg_addr = 4'd4; #1;
    n_chk++; if (cfg_rdata !== 32'd100) $display("FAIL reset_limit3 got %0d want 100", cfg_rdata); else n_pass++;
    cfg_addr = 4'(N + 1); #1;
    n_chk++; if (cfg_rdata !== 32'd0) $display("FAIL reset_pending got %h want 0", cfg_rdata); else n_pass++;
    cfg_addr = 4'(N + 2); #1;
    n_chk++; if (cfg_rdata !== 32'd0) $display("FAIL reset_overrun got %h want 0", cfg_rdata); else n_pass++;
    cfg_addr = 4'd9; #1;
    n_chk++; if (cfg_rdata !== 32'd0) $display("FAIL unmapped_read got %h want 0", cfg_rdata); else n_pass++;
    cfg_addr = 4'(N + 1);
    @(posedge clk);
    #1 rstn = 1'b1;
    m_reset();
  endtask

  task automatic test_timer();
    repeat (99) tick();
    n_chk++; if (irq !== 1'b0) $display("FAIL timer_edge99 irq=%0b want 0", irq); else n_pass++;
    tick();
    n_chk++; if (irq !== 1'b1 || irq_id !== 3'd0) $display("FAIL timer_edge100 irq=%0b id=%0d want 1/0", irq, irq_id); else n_pass++;
    repeat (100) tick();
    n_chk++; if (irq !== 1'b1 || cfg_rdata !== 32'h1) $display("FAIL timer_merge irq=%0b pend=%h want 1/1", irq, cfg_rdata); else n_pass++;
`ifdef IRQ_HUB_OVERRUN_EN
    cfg_addr = 4'(N + 2); #1;
    n_chk++; if (cfg_rdata !== 32'h1) $display("FAIL timer_overrun got %h want 1", cfg_rdata); else n_pass++;
    cfg_addr = 4'(N + 1);
`endif
    ack();
    n_chk++; if (irq !== 1'b0 || cfg_rdata !== 32'h0) $display("FAIL timer_ack irq=%0b pend=%h want 0/0", irq, cfg_rdata); else n_pass++;
    cfg_write(N + 2, 32'hf);
    cfg_write(1, 32'd0);
    cfg_addr = 4'(N + 2); #1;
    n_chk++; if (cfg_rdata !== 32'h0) $display("FAIL overrun_clear got %h want 0", cfg_rdata); else n_pass++;
    cfg_addr = 4'd1; #1;
    n_chk++; if (cfg_rdata !== 32'd0) $display("FAIL limit_write got %0d want 0", cfg_rdata); else n_pass++;
    cfg_addr = 4'(N + 1);
  endtask

  task automatic test_ext();
    repeat (10) tick();
    ext_src[1] = 1'b1;
    tick();
    n_chk++; if (irq !== 1'b0) $display("FAIL ext_edge11 irq=%0b want 0", irq); else n_pass++;
    tick();
    n_chk++; if (irq !== 1'b0) $display("FAIL ext_edge12 irq=%0b want 0", irq); else n_pass++;
    tick();
    n_chk++; if (irq !== 1'b1 || irq_id !== 3'd1 || cfg_rdata !== 32'h2) $display("FAIL ext_edge13 irq=%0b id=%0d pend=%h want 1/1/2", irq, irq_id, cfg_rdata); else n_pass++;
    ack();
    n_chk++; if (irq !== 1'b0 || cfg_rdata !== 32'h0) $display("FAIL ext_ack irq=%0b pend=%h want 0/0", irq, cfg_rdata); else n_pass++;
    ext_src[1] = 1'b0;
    repeat (3) tick();
    n_chk++; if (irq !== 1'b0) $display("FAIL ext_fall irq=%0b want 0", irq); else n_pass++;
  endtask

  task automatic test_priority();
    ext_src = 4'b1010;
    repeat (3) tick();
    ext_src = '0;
    n_chk++; if (irq !== 1'b1 || irq_id !== 3'd1 || cfg_rdata !== 32'ha) $display("FAIL prio_first irq=%0b id=%0d pend=%h want 1/1/a", irq, irq_id, cfg_rdata); else n_pass++;
    ack();
    n_chk++; if (irq !== 1'b1 || irq_id !== 3'd3) $display("FAIL prio_second irq=%0b id=%0d want 1/3", irq, irq_id); else n_pass++;
    ack();
    n_chk++; if (irq !== 1'b0 || irq_id !== 3'd0) $display("FAIL prio_done irq=%0b id=%0d want 0/0", irq, irq_id); else n_pass++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_chk++; if (irq !== 1'b0 || cfg_rdata !== 32'h0) $display("FAIL idle_ack irq=%0b pend=%h want 0/0", irq, cfg_rdata); else n_pass++;
  endtask

  task automatic test_overrun();
    cfg_write(1, 32'd5);
    repeat (4) tick();
    n_chk++; if (irq !== 1'b0) $display("FAIL lim5_edge4 irq=%0b want 0", irq); else n_pass++;
    tick();
    n_chk++; if (irq !== 1'b1 || irq_id !== 3'd0) $display("FAIL lim5_edge5 irq=%0b id=%0d want 1/0", irq, irq_id); else n_pass++;
    repeat (4) tick();
    ack();
    n_chk++; if (irq !== 1'b1 || cfg_rdata !== 32'h1) $display("FAIL event_beats_ack irq=%0b pend=%h want 1/1", irq, cfg_rdata); else n_pass++;
`ifdef IRQ_HUB_OVERRUN_EN
    cfg_addr = 4'(N + 2); #1;
    n_chk++; if (cfg_rdata !== 32'h1) $display("FAIL ack_overrun got %h want 1", cfg_rdata); else n_pass++;
    cfg_addr = 4'(N + 1);
`endif
    ack();
    n_chk++; if (irq !== 1'b0) $display("FAIL lim5_ack irq=%0b want 0", irq); else n_pass++;
    cfg_write(1, 32'd0);
    cfg_write(N + 2, 32'h1);
    cfg_addr = 4'(N + 2); #1;
    n_chk++; if (cfg_rdata !== 32'h0) $display("FAIL overrun_clear2 got %h want 0", cfg_rdata); else n_pass++;
    cfg_addr = 4'(N + 1);
  endtask

  task automatic test_enable();
    cfg_write(0, 32'h0);
    ext_src[2] = 1'b1;
    repeat (3) tick();
    ext_src[2] = 1'b0;
    n_chk++; if (irq !== 1'b0 || irq_id !== 3'd0 || cfg_rdata !== 32'h4) $display("FAIL disabled_pend irq=%0b id=%0d pend=%h want 0/0/4", irq, irq_id, cfg_rdata); else n_pass++;
    cfg_write(0, 32'hf);
    n_chk++; if (irq !== 1'b1 || irq_id !== 3'd2) $display("FAIL reenable irq=%0b id=%0d want 1/2", irq, irq_id); else n_pass++;
    ack();
    n_chk++; if (irq !== 1'b0) $display("FAIL enable_ack irq=%0b want 0", irq); else n_pass++;
  endtask

  task automatic test_reset_mid();
    cfg_write(1, 32'd100);
    ext_src[3] = 1'b1;
    repeat (3) tick();
    ext_src[3] = 1'b0;
    repeat (47) tick();
    n_chk++; if (irq !== 1'b1 || irq_id !== 3'd3) $display("FAIL pre_reset irq=%0b id=%0d want 1/3", irq, irq_id); else n_pass++;
    rstn = 1'b0;
    #1;
    n_chk++; if (irq !== 1'b0 || irq_id !== 3'd0) $display("FAIL async_reset irq=%0b id=%0d want 0/0", irq, irq_id); else n_pass++;
    @(posedge clk);
    #1 rstn = 1'b1;
    m_reset();
    repeat (99) tick();
    n_chk++; if (irq !== 1'b0 || cfg_rdata !== 32'h0) $display("FAIL post_reset_99 irq=%0b pend=%h want 0/0", irq, cfg_rdata); else n_pass++;
    tick();
    n_chk++; if (irq !== 1'b1 || irq_id !== 3'd0) $display("FAIL post_reset_100 irq=%0b id=%0d want 1/0", irq, irq_id); else n_pass++;
    ack();
  endtask

  task automatic test_random();
    int a;
    for (int c = 0; c < 3000; c++) begin
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = 4'($urandom_range(0, 15));
      a = int'(cfg_addr);
      cfg_wdata = (a >= 1 && a <= N) ? 32'($urandom_range(0, 9)) : $urandom;
      irq_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        a = $urandom_range(1, N - 1);
        ext_src[a] = ~ext_src[a];
        a = int'(cfg_addr);
      end
      #1;
      n_chk++; if (cfg_rdata !== m_rd(a)) $display("FAIL rand_rdata cyc=%0d addr=%0d got %h want %h", c, a, cfg_rdata, m_rd(a)); else n_pass++;
      tick();
      n_chk++; if (irq !== (m_act() != '0) || irq_id !== 3'(m_id())) $display("FAIL rand_irq cyc=%0d irq=%0b id=%0d want %0b/%0d", c, irq, irq_id, m_act() != '0, m_id()); else n_pass++;
    end
    cfg_we = 1'b0;
    irq_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_ext();
    test_priority();
    test_overrun();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
